// File: rtl/multiport_regfile_if.sv
// Bus interface for multiport_regfile.
//   master modport : drives read/write addresses, write data, clear request and
//                    init hook; observes read data, clr_busy and entry state.
//   slave modport  : the register file side (mirror of master).
// clk and rst are not carried here; they stay plain ports on the register file.
interface multiport_regfile_if #(
    parameter int N_ENTRIES     = 32,
    parameter int ENTRY_WIDTH   = 32,
    parameter int N_READ_PORTS  = 2,
    parameter int N_WRITE_PORTS = 1
) ();
    localparam int PTR_WIDTH = $clog2(N_ENTRIES);

    logic [N_READ_PORTS-1:0][PTR_WIDTH-1:0]    rd_addr;
    logic [N_READ_PORTS-1:0][ENTRY_WIDTH-1:0]  rd_data;
    logic [N_WRITE_PORTS-1:0]                  wr_en;
    logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]   wr_addr;
    logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0] wr_data;
    logic                                      clr_req;
    logic                                      clr_busy;
    logic                                      init;
    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]     init_entry_reg_state;
    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]     current_entry_reg_state;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_req, init, init_entry_reg_state,
        input  rd_data, clr_busy, current_entry_reg_state
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_req, init, init_entry_reg_state,
        output rd_data, clr_busy, current_entry_reg_state
    );
endinterface

// File: rtl/multiport_regfile.sv
// Multi-port register file with combinational reads, synchronous writes and a
// multi-cycle bulk clear engine.
//   clk  : single clock, all state updates on the rising edge
//   rst  : synchronous, active-high reset (zeroes entries, aborts clear)
//   bus  : multiport_regfile_if.slave
//          rd_addr/rd_data      - N_READ_PORTS combinational read ports
//          wr_en/wr_addr/wr_data- N_WRITE_PORTS synchronous write ports,
//                                 highest-indexed port wins on address clash
//          clr_req/clr_busy     - bulk clear, CLR_PER_CYCLE entries per cycle
//          init/init_entry_reg_state - test hook loading the whole array
//          current_entry_reg_state   - live contents of every entry
// Optional feature: define MULTIPORT_REGFILE_BYPASS_EN to forward same-cycle
// write data to matching read ports.
module multiport_regfile #(
    parameter int N_ENTRIES     = 32,
    parameter int ENTRY_WIDTH   = 32,
    parameter int N_READ_PORTS  = 2,
    parameter int N_WRITE_PORTS = 1,
    parameter int ZERO_REG      = 1,
    parameter int CLR_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    multiport_regfile_if.slave   bus
);
    localparam int PTR_WIDTH = $clog2(N_ENTRIES);

    typedef enum logic {
        IDLE,
        CLEARING
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic [ENTRY_WIDTH-1:0] mem_q [N_ENTRIES];
    logic [ENTRY_WIDTH-1:0] mem_d [N_ENTRIES];
    logic                   clr_busy;

    assign clr_busy     = (state_q == CLEARING);
    assign bus.clr_busy = clr_busy;

    // Next-state: init > clear > port writes (rst handled in the register).
    always_comb begin
        logic [PTR_WIDTH-1:0] idx;
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_d     = mem_q;
        idx       = '0;
        if (bus.init) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                mem_d[i] = bus.init_entry_reg_state[i];
            end
            state_d   = IDLE;
            clr_ptr_d = '0;
        end else if (state_q == CLEARING) begin
            // Block is aligned to CLR_PER_CYCLE, so idx never wraps mid-block.
            for (int unsigned i = 0; i < CLR_PER_CYCLE; i++) begin
                idx        = clr_ptr_q + PTR_WIDTH'(i);
                mem_d[idx] = '0;
            end
            clr_ptr_d = clr_ptr_q + PTR_WIDTH'(CLR_PER_CYCLE);
            // Terminate on the last block rather than on pointer wrap.
            if (clr_ptr_q == PTR_WIDTH'(N_ENTRIES - CLR_PER_CYCLE)) begin
                state_d = IDLE;
            end
        end else begin
            // Writes in the request cycle still land; the clear wipes them.
            for (int unsigned w = 0; w < N_WRITE_PORTS; w++) begin
                if (bus.wr_en[w]) begin
                    mem_d[bus.wr_addr[w]] = bus.wr_data[w];
                end
            end
            if (bus.clr_req) begin
                state_d   = CLEARING;
                clr_ptr_d = '0;
            end
        end
        if (ZERO_REG != 0) begin
            mem_d[0] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clr_ptr_q <= '0;
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            mem_q     <= mem_d;
        end
    end

    // Read ports.
    always_comb begin
        bus.rd_data = '0;
        for (int unsigned p = 0; p < N_READ_PORTS; p++) begin
            bus.rd_data[p] = mem_q[bus.rd_addr[p]];
`ifdef MULTIPORT_REGFILE_BYPASS_EN
            if (!clr_busy && !bus.init && !rst) begin
                for (int unsigned w = 0; w < N_WRITE_PORTS; w++) begin
                    if (bus.wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[p])) begin
                        bus.rd_data[p] = bus.wr_data[w];
                    end
                end
            end
`endif
            if ((ZERO_REG != 0) && (bus.rd_addr[p] == '0)) begin
                bus.rd_data[p] = '0;
            end
        end
    end

    always_comb begin
        bus.current_entry_reg_state = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            bus.current_entry_reg_state[i] = mem_q[i];
        end
    end
endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter N_ENTRIES, default 32, number of entries, power of two, >= 2.
REQ-002 Parameter ENTRY_WIDTH, default 32, bits per entry.
REQ-003 Parameter N_READ_PORTS, default 2, independent combinational read ports.
REQ-004 Parameter N_WRITE_PORTS, default 1, independent synchronous write ports.
REQ-005 Parameter ZERO_REG, default 1; when 1, entry 0 reads zero and ignores writes.
REQ-006 Parameter CLR_PER_CYCLE, default 4, entries zeroed per clear cycle; power of two dividing N_ENTRIES.
REQ-007 Derived: PTR_WIDTH = $clog2(N_ENTRIES).
REQ-008 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-009 Port rst, input, 1, reset, synchronous and active-high.
REQ-010 Port rd_addr, input, N_READ_PORTS x PTR_WIDTH, read address per port.
REQ-011 Port rd_data, output, N_READ_PORTS x ENTRY_WIDTH, read data per port.
REQ-012 Port wr_en, input, N_WRITE_PORTS, write enable per port.
REQ-013 Port wr_addr, input, N_WRITE_PORTS x PTR_WIDTH, write address per port.
REQ-014 Port wr_data, input, N_WRITE_PORTS x ENTRY_WIDTH, write data per port.
REQ-015 Port clr_req, input, 1, one-cycle request to start a bulk clear.
REQ-016 Port clr_busy, output, 1, high while the bulk clear runs.
REQ-017 Port init, input, 1, test hook: load init_entry_reg_state.
REQ-018 Port init_entry_reg_state, input, N_ENTRIES x ENTRY_WIDTH, state loaded on init.
REQ-019 Port current_entry_reg_state, output, N_ENTRIES x ENTRY_WIDTH, live entry contents; entry 0 forced zero when ZERO_REG=1.

Function
REQ-020 Reads SHALL be combinational, zero-cycle latency: rd_data[p] = entry[rd_addr[p]].
REQ-021 A write with wr_en[w]=1 SHALL update entry[wr_addr[w]] at the next rising edge.
REQ-022 Same-cycle writes to the same address SHALL resolve to the highest-indexed write port.
REQ-023 With ZERO_REG=1, writes to address 0 SHALL be dropped and reads of address 0 SHALL return zero, including under bypass.
REQ-024 Clear FSM states: IDLE, CLEARING; state register and clr_ptr (PTR_WIDTH bits) are internal.
REQ-025 IDLE -> CLEARING on clr_req=1; clr_ptr loads 0; clr_busy asserts the cycle after the request.
REQ-026 Each CLEARING cycle SHALL zero entries clr_ptr .. clr_ptr+CLR_PER_CYCLE-1 and advance clr_ptr by CLR_PER_CYCLE.
REQ-027 CLEARING -> IDLE after the cycle clearing the last block; clear takes exactly N_ENTRIES/CLR_PER_CYCLE cycles.
REQ-028 clr_req while CLEARING SHALL be ignored; clr_ptr wrap-around SHALL NOT restart the clear.
REQ-029 All writes while clr_busy=1 SHALL be dropped; reads return current contents (partially cleared).
REQ-030 Priority per edge: rst > init > clear > port writes.
REQ-031 init=1 SHALL load all entries from init_entry_reg_state at the next edge and force FSM to IDLE.

Reset
REQ-032 rst=1 at a rising edge SHALL zero all entries, set FSM IDLE, clr_ptr 0, clr_busy 0.
REQ-033 Reset mid-clear SHALL abort the clear; state as REQ-032 the following cycle.
REQ-034 After reset, all rd_data outputs SHALL be zero until the first write completes.

Configuration
REQ-035 Macro MULTIPORT_REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-036 Defined: if any wr_en[w] targets rd_addr[p] in the same cycle and clr_busy=0, init=0, rst=0, rd_data[p] SHALL return that wr_data (highest-indexed winner).
REQ-037 Undefined: rd_data SHALL return stored contents only; new data visible the cycle after the write.

Verification
REQ-038 Reset, then rd_addr={0,5} -> rd_data={0,0}; clr_busy=0.
REQ-039 Write port 0 addr 3 data 32'h12345678, next cycle read addr 3 -> 32'h12345678; same-cycle read returns it only with bypass enabled.
REQ-040 Ports 0 and 1 both write addr 7 (32'hAAAA0000, 32'hBBBB0000) -> entry 7 = 32'hBBBB0000.
REQ-041 Write addr 0 data 32'hFFFFFFFF with ZERO_REG=1 -> read addr 0 = 0, with and without bypass.
REQ-042 init with all entries 32'hDEADBEEF, pulse clr_req -> clr_busy high 8 cycles (32/4); entry 31 nonzero until last cycle; writes during clear dropped; all zero after.
REQ-043 rst asserted on third clear cycle -> next cycle clr_busy=0, all entries 0, fresh clr_req clears normally.
